// File: rtl/dp_ram_pkg.sv
// Shared types and sizing helpers for the byte-enabled dual-port RAM.
package dp_ram_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned BYTE_W_DEF = 8;

    localparam int unsigned NB    = DATA_W_DEF / BYTE_W_DEF;
    localparam int unsigned DEPTH = 32'(1) << ADDR_W_DEF;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    function automatic int unsigned nb_of(input int unsigned data_w, input int unsigned byte_w);
        return data_w / byte_w;
    endfunction

    function automatic int unsigned depth_of(input int unsigned addr_w);
        return 32'(1) << addr_w;
    endfunction

endpackage

// File: rtl/dp_ram_be_if.sv
// Bus bundle for both RAM ports plus the clear/collision sideband.
interface dp_ram_be_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned BYTE_W = 8
) ();
    import dp_ram_pkg::*;

    localparam int unsigned LANES = nb_of(DATA_W, BYTE_W);

    logic              clr_req;
    logic              busy;
    logic              collision;

    logic              p1_en;
    logic              p1_we;
    logic [LANES-1:0]  p1_be;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_rvalid;

    logic              p2_en;
    logic              p2_we;
    logic [LANES-1:0]  p2_be;
    logic [ADDR_W-1:0] p2_addr;
    logic [DATA_W-1:0] p2_wdata;
    logic [DATA_W-1:0] p2_rdata;
    logic              p2_rvalid;

    modport master (
        output clr_req,
        output p1_en, p1_we, p1_be, p1_addr, p1_wdata,
        output p2_en, p2_we, p2_be, p2_addr, p2_wdata,
        input  busy, collision,
        input  p1_rdata, p1_rvalid,
        input  p2_rdata, p2_rvalid
    );

    modport slave (
        input  clr_req,
        input  p1_en, p1_we, p1_be, p1_addr, p1_wdata,
        input  p2_en, p2_we, p2_be, p2_addr, p2_wdata,
        output busy, collision,
        output p1_rdata, p1_rvalid,
        output p2_rdata, p2_rvalid
    );

endinterface

// File: rtl/dp_ram_clr_seq.sv
// Zero-fill sequencer: walks every address once after reset or on clr_req.
module dp_ram_clr_seq
    import dp_ram_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we
);

    clr_state_e        state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic              busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy_q <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            busy_q <= (state_n == CLEAR);
        end
    end

    // Requests arriving mid-clear do not restart the walk.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            CLEAR: begin
                if (&cnt) begin
                    state_n = READY;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + ADDR_W'(1);
                end
            end
            READY: begin
                if (clr_req) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = CLEAR;
                cnt_n   = '0;
            end
        endcase
    end

    assign busy     = busy_q;
    assign clr_we   = busy_q;
    assign clr_addr = cnt;

endmodule

// File: rtl/dp_ram_be.sv
// True dual-port RAM with byte enables, read-first ports and a zero-fill sequencer.
module dp_ram_be
    import dp_ram_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned BYTE_W  = 8,
    parameter int unsigned OUT_REG = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    dp_ram_be_if.slave   bus
);

    localparam int unsigned LANES = nb_of(DATA_W, BYTE_W);
    localparam int unsigned WORDS = depth_of(ADDR_W);

    typedef logic [LANES-1:0][BYTE_W-1:0] word_t;

    word_t mem [WORDS];

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    dp_ram_clr_seq #(
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (bus.clr_req),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    logic              wr1;
    logic              wr2;
    logic              rreq1;
    logic              rreq2;
    logic [ADDR_W-1:0] wa1;
    logic [LANES-1:0]  wbe1;
    word_t             wd1;
    word_t             wd2;

    // Port-1 write path is borrowed by the clear sequencer while busy.
    always_comb begin
        wr1  = clr_we;
        wa1  = clr_addr;
        wbe1 = '1;
        wd1  = '0;
        if (!busy) begin
            wr1  = bus.p1_en & bus.p1_we;
            wa1  = bus.p1_addr;
            wbe1 = bus.p1_be;
            wd1  = word_t'(bus.p1_wdata);
        end
    end

    assign wr2   = !busy & bus.p2_en & bus.p2_we;
    assign wd2   = word_t'(bus.p2_wdata);
    assign rreq1 = !busy & bus.p1_en & !bus.p1_we;
    assign rreq2 = !busy & bus.p2_en & !bus.p2_we;

    // Port 1 is applied last so its lanes win a same-address collision.
    always_ff @(posedge clk) begin
        if (wr2) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.p2_be[i]) mem[bus.p2_addr][i] <= wd2[i];
            end
        end
        if (wr1) begin
            for (int i = 0; i < LANES; i++) begin
                if (wbe1[i]) mem[wa1][i] <= wd1[i];
            end
        end
    end

    logic              rv1_s;
    logic              rv2_s;
    logic [DATA_W-1:0] rdat1_s;
    logic [DATA_W-1:0] rdat2_s;

    // First read stage; non-blocking sampling gives read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv1_s   <= 1'b0;
            rv2_s   <= 1'b0;
            rdat1_s <= '0;
            rdat2_s <= '0;
        end else begin
            rv1_s <= rreq1;
            rv2_s <= rreq2;
            if (rreq1) rdat1_s <= mem[bus.p1_addr];
            if (rreq2) rdat2_s <= mem[bus.p2_addr];
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic              rv1_o;
        logic              rv2_o;
        logic [DATA_W-1:0] rdat1_o;
        logic [DATA_W-1:0] rdat2_o;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rv1_o   <= 1'b0;
                rv2_o   <= 1'b0;
                rdat1_o <= '0;
                rdat2_o <= '0;
            end else begin
                rv1_o <= rv1_s;
                rv2_o <= rv2_s;
                if (rv1_s) rdat1_o <= rdat1_s;
                if (rv2_s) rdat2_o <= rdat2_s;
            end
        end

        assign bus.p1_rdata  = rdat1_o;
        assign bus.p1_rvalid = rv1_o;
        assign bus.p2_rdata  = rdat2_o;
        assign bus.p2_rvalid = rv2_o;
    end else begin : g_noreg
        assign bus.p1_rdata  = rdat1_s;
        assign bus.p1_rvalid = rv1_s;
        assign bus.p2_rdata  = rdat2_s;
        assign bus.p2_rvalid = rv2_s;
    end

    logic collision_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= wr1 & wr2 & (wa1 == bus.p2_addr) & (|(wbe1 & bus.p2_be));
        end
    end

    assign bus.collision = collision_q;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_dp_ram_be.sv
// Drives two RAM instances (1- and 2-cycle read latency) with shared stimulus against a word-level model.
module tb_dp_ram_be;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned BW    = 8;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_req;
    logic        p1_en, p1_we, p2_en, p2_we;
    logic [3:0]  p1_be, p2_be, p1_addr, p2_addr;
    logic [31:0] p1_wdata, p2_wdata;

    logic        busy_o [2];
    logic        coll_o [2];
    logic        rv1_o  [2];
    logic        rv2_o  [2];
    logic [31:0] rd1_o  [2];
    logic [31:0] rd2_o  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dp_ram_be_if #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(BW)) bus ();

        assign bus.clr_req  = clr_req;
        assign bus.p1_en    = p1_en;
        assign bus.p1_we    = p1_we;
        assign bus.p1_be    = p1_be;
        assign bus.p1_addr  = p1_addr;
        assign bus.p1_wdata = p1_wdata;
        assign bus.p2_en    = p2_en;
        assign bus.p2_we    = p2_we;
        assign bus.p2_be    = p2_be;
        assign bus.p2_addr  = p2_addr;
        assign bus.p2_wdata = p2_wdata;

        dp_ram_be #(.DATA_W(DW), .ADDR_W(AW), .BYTE_W(BW), .OUT_REG(g)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign busy_o[g] = bus.busy;
        assign coll_o[g] = bus.collision;
        assign rv1_o[g]  = bus.p1_rvalid;
        assign rv2_o[g]  = bus.p2_rvalid;
        assign rd1_o[g]  = bus.p1_rdata;
        assign rd2_o[g]  = bus.p2_rdata;
    end

    // Reference model: word array, remaining clear cycles, expected-read queues.
    logic [31:0] mem_m [DEPTH];
    int          clear_left = DEPTH;
    int          edge_n     = 0;
    logic        exp_busy   = 1'b1;
    logic        exp_coll   = 1'b0;
    exp_t        q1[$];
    exp_t        q2[$];
    int          ptr [2][2];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at t=%0t", name, got, want, $time);
        end
    endtask

    task automatic model_edge();
        edge_n++;
        exp_coll = 1'b0;
        if (clear_left > 0) begin
            clear_left--;
        end else begin
            if (p1_en && !p1_we) q1.push_back('{data: mem_m[p1_addr], due: edge_n});
            if (p2_en && !p2_we) q2.push_back('{data: mem_m[p2_addr], due: edge_n});
            exp_coll = p1_en && p1_we && p2_en && p2_we && (p1_addr == p2_addr)
                       && ((p1_be & p2_be) != 4'h0);
            if (p2_en && p2_we) mem_m[p2_addr] = merge(mem_m[p2_addr], p2_wdata, p2_be);
            if (p1_en && p1_we) mem_m[p1_addr] = merge(mem_m[p1_addr], p1_wdata, p1_be);
            if (clr_req) begin
                for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
                clear_left = DEPTH;
            end
        end
        exp_busy = (clear_left > 0);
    endtask

    task automatic mon(input int d, input int p, input logic rv, input logic [31:0] rd);
        exp_t e;
        logic have;
        have = 1'b0;
        e    = '{data: '0, due: 0};
        if (p == 0 && ptr[d][0] < q1.size()) begin e = q1[ptr[d][0]]; have = 1'b1; end
        if (p == 1 && ptr[d][1] < q2.size()) begin e = q2[ptr[d][1]]; have = 1'b1; end
        if (have && (e.due + d == edge_n)) begin
            ptr[d][p]++;
            checks++;
            if (!rv) begin
                errors++;
                $display("FAIL rvalid_missing dut%0d p%0d got 0 want 1 edge %0d", d, p + 1, edge_n);
            end else if (rd !== e.data) begin
                errors++;
                $display("FAIL rdata dut%0d p%0d got %h want %h edge %0d", d, p + 1, rd, e.data, edge_n);
            end
        end else if (rv) begin
            checks++;
            errors++;
            $display("FAIL rvalid_unexpected dut%0d p%0d got 1 want 0 edge %0d", d, p + 1, edge_n);
        end
    endtask

    // Monitor: compares responses away from the active edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            mon(d, 0, rv1_o[d], rd1_o[d]);
            mon(d, 1, rv2_o[d], rd2_o[d]);
            chk($sformatf("busy_dut%0d", d), 32'(busy_o[d]), 32'(exp_busy));
            chk($sformatf("collision_dut%0d", d), 32'(coll_o[d]), 32'(exp_coll));
        end
    end

    task automatic idle_inputs();
        clr_req = 1'b0;
        p1_en = 1'b0; p1_we = 1'b0; p1_be = '0; p1_addr = '0; p1_wdata = '0;
        p2_en = 1'b0; p2_we = 1'b0; p2_be = '0; p2_addr = '0; p2_wdata = '0;
    endtask

    task automatic set_p1(input logic we, input logic [3:0] be, input logic [3:0] a,
                          input logic [31:0] dat);
        p1_en = 1'b1; p1_we = we; p1_be = be; p1_addr = a; p1_wdata = dat;
    endtask

    task automatic set_p2(input logic we, input logic [3:0] be, input logic [3:0] a,
                          input logic [31:0] dat);
        p2_en = 1'b1; p2_we = we; p2_be = be; p2_addr = a; p2_wdata = dat;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        idle_inputs();
    endtask

    // Pending reads are discarded; the array contents are re-zeroed by the clear pass.
    task automatic do_reset();
        rst_n      = 1'b0;
        clear_left = DEPTH;
        exp_busy   = 1'b1;
        exp_coll   = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        for (int d = 0; d < 2; d++) begin
            ptr[d][0] = q1.size();
            ptr[d][1] = q2.size();
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_p1_rdata_dut%0d", d), rd1_o[d], 32'h0);
            chk($sformatf("rst_p2_rdata_dut%0d", d), rd2_o[d], 32'h0);
            chk($sformatf("rst_rvalid_dut%0d", d), {30'h0, rv2_o[d], rv1_o[d]}, 32'h0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] a1, a2;
        rst_n = 1'b0;
        idle_inputs();
        do_reset();
        repeat (DEPTH) step();

        // Every address reads zero after the initial clear.
        for (int a = 0; a < DEPTH; a++) begin
            set_p1(1'b0, 4'h0, 4'(a), 32'h0);
            set_p2(1'b0, 4'h0, 4'(DEPTH - 1 - a), 32'h0);
            step();
        end

        // Byte lanes: expect 0xAA22CC44 at address 3.
        set_p1(1'b1, 4'hF, 4'd3, 32'hAABBCCDD); step();
        set_p1(1'b1, 4'h5, 4'd3, 32'h11223344); step();
        set_p2(1'b0, 4'h0, 4'd3, 32'h0);        step();

        // Cross-port read-first on address 7.
        set_p1(1'b1, 4'h1, 4'd7, 32'h55);
        set_p2(1'b0, 4'h0, 4'd7, 32'h0);
        step();
        set_p2(1'b0, 4'h0, 4'd7, 32'h0);
        step();

        // Write/write collision on address 9.
        set_p1(1'b1, 4'h1, 4'd9, 32'h12);
        set_p2(1'b1, 4'h1, 4'd9, 32'h34);
        step();
        set_p1(1'b0, 4'h0, 4'd9, 32'h0);
        step();
        step();

        // Clear during use: same-cycle read serviced, read while busy dropped.
        set_p1(1'b1, 4'hF, 4'd5, 32'hFFFFFFFF); step();
        clr_req = 1'b1;
        set_p2(1'b0, 4'h0, 4'd5, 32'h0);
        step();
        set_p1(1'b0, 4'h0, 4'd5, 32'h0);
        clr_req = 1'b1;
        step();
        for (int i = 0; i < 40 && exp_busy; i++) step();
        set_p1(1'b0, 4'h0, 4'd5, 32'h0);
        step();

        // Randomised traffic with occasional clears and frequent address overlap.
        for (int n = 0; n < 400; n++) begin
            a1 = 4'($urandom_range(0, DEPTH - 1));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 4'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 3) != 0)
                set_p1(1'($urandom_range(0, 1)), 4'($urandom), a1, $urandom);
            if ($urandom_range(0, 3) != 0)
                set_p2(1'($urandom_range(0, 1)), 4'($urandom), a2, $urandom);
            clr_req = ($urandom_range(0, 79) == 0);
            step();
        end
        repeat (DEPTH + 2) step();

        // Reset with reads in flight, then reset again partway through the clear.
        set_p1(1'b0, 4'h0, 4'd2, 32'h0);
        set_p2(1'b0, 4'h0, 4'd3, 32'h0);
        step();
        do_reset();
        repeat (6) step();
        do_reset();
        repeat (DEPTH) step();
        for (int a = 0; a < 4; a++) begin
            set_p1(1'b0, 4'h0, 4'(a), 32'h0);
            set_p2(1'b1, 4'h3, 4'(a + 8), 32'hCAFE0000 + 32'(a));
            step();
        end
        for (int a = 0; a < 4; a++) begin
            set_p2(1'b0, 4'h0, 4'(a + 8), 32'h0);
            step();
        end
        repeat (4) step();

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("drained_p1_dut%0d", d), 32'(ptr[d][0]), 32'(q1.size()));
            chk($sformatf("drained_p2_dut%0d", d), 32'(ptr[d][1]), 32'(q2.size()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
